// File: rtl/multiplier_seq_if.sv
// Operand/product handshake bundle for multiplier_seq.
// signed_mode exists only when MULT_SIGNED_EN is defined.
interface multiplier_seq_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
`ifdef MULT_SIGNED_EN
  logic           signed_mode;
`endif
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] o;

`ifdef MULT_SIGNED_EN
  modport master (output in_valid, x, y, signed_mode, out_ready,
                  input  in_ready, out_valid, o);
  modport slave  (input  in_valid, x, y, signed_mode, out_ready,
                  output in_ready, out_valid, o);
`else
  modport master (output in_valid, x, y, out_ready,
                  input  in_ready, out_valid, o);
  modport slave  (input  in_valid, x, y, out_ready,
                  output in_ready, out_valid, o);
`endif
endinterface

// File: rtl/multiplier_seq.sv
// Radix-2^K sequential shift-add multiplier, W x W -> 2W, K multiplier bits per clock.
// Define MULT_SIGNED_EN to add the per-transaction signed_mode input and sign correction.
module multiplier_seq #(
  parameter int W = 8,
  parameter int K = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  multiplier_seq_if.slave        mul_if,
  output logic [1:0]             state_dbg_o
);

  localparam int NDIG = W / K;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] digit_ext, pp, x_ext;
`ifdef MULT_SIGNED_EN
  logic           sgn_q, sgn_d;
`endif

  // Handshakes: a transfer happens on any rising edge where valid && ready are both high;
  // ready/valid are decoded from state only, so neither depends on the partner's signal.
  assign mul_if.in_ready  = (state_q == IDLE);
  assign mul_if.out_valid = (state_q == DONE);
  assign mul_if.o         = acc_q;
  assign state_dbg_o      = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef MULT_SIGNED_EN
    sgn_d    = sgn_q;
`endif

    // mcand_q is x pre-shifted to the current digit's weight; mplier_q shifts the next digit down.
    digit_ext = {{(2*W-K){1'b0}}, mplier_q[K-1:0]};
    pp        = mcand_q * digit_ext;
    x_ext     = {{W{1'b0}}, mul_if.x};
`ifdef MULT_SIGNED_EN
    // The MSB of y weighs -2^(W-1); the top digit added it as +2^(W-1), so remove 2 * x * 2^(W-1).
    if (sgn_q && (cnt_q == LAST_DIG) && mplier_q[K-1]) begin
      pp = pp - (mcand_q << K);
    end
    if (mul_if.signed_mode) begin
      x_ext = {{W{mul_if.x[W-1]}}, mul_if.x};
    end
`endif

    case (state_q)
      IDLE: begin
        if (mul_if.in_valid) begin
          state_d  = CALC;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = x_ext;
          mplier_d = mul_if.y;
`ifdef MULT_SIGNED_EN
          sgn_d    = mul_if.signed_mode;
`endif
        end
      end
      CALC: begin
        acc_d    = acc_q + pp;
        mcand_d  = mcand_q << K;
        mplier_d = mplier_q >> K;
        if (cnt_q == LAST_DIG) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (mul_if.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef MULT_SIGNED_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef MULT_SIGNED_EN
      sgn_q    <= sgn_d;
`endif
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: latency, sweep over K/W, signed cases, backpressure, reset, input hold.
module tb_multiplier_seq;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  multiplier_seq_if #(.W(8)) mif ();
  multiplier_seq_if #(.W(8)) s1_if ();
  multiplier_seq_if #(.W(8)) s4_if ();
  multiplier_seq_if #(.W(4)) s41_if ();
  logic [1:0] st, st1, st4, st41;

  multiplier_seq #(.W(8), .K(2)) dut     (.clk(clk), .rst(rst), .mul_if(mif),    .state_dbg_o(st));
  multiplier_seq #(.W(8), .K(1)) dut_k1  (.clk(clk), .rst(rst), .mul_if(s1_if),  .state_dbg_o(st1));
  multiplier_seq #(.W(8), .K(4)) dut_k4  (.clk(clk), .rst(rst), .mul_if(s4_if),  .state_dbg_o(st4));
  multiplier_seq #(.W(4), .K(1)) dut_w4  (.clk(clk), .rst(rst), .mul_if(s41_if), .state_dbg_o(st41));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!mif.out_valid && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  // One full transaction on the main W=8/K=2 instance, starting from IDLE and ending back in IDLE.
  task automatic run_main(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [15:0] exp);
    int lat;
    mif.x = a;
    mif.y = b;
`ifdef MULT_SIGNED_EN
    mif.signed_mode = s;
`else
    if (s) $display("note: signed case skipped in unsigned build");
`endif
    mif.in_valid  = 1'b1;
    mif.out_ready = 1'b1;
    tick;
    mif.in_valid = 1'b0;
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(4));
    check({tag, "_o"}, 64'(mif.o), 64'(exp));
    tick;
  endtask

  task automatic sweep(input logic [7:0] a, input logic [7:0] b);
    int l1, l4, l41;
    logic [15:0] p1, p4;
    logic [7:0]  p41;
    logic [15:0] e8;
    logic [7:0]  e4;
    e8 = {8'd0, a} * {8'd0, b};
    e4 = {4'd0, a[3:0]} * {4'd0, b[3:0]};
    s1_if.x = a;  s1_if.y = b;
    s4_if.x = a;  s4_if.y = b;
    s41_if.x = a[3:0]; s41_if.y = b[3:0];
    s1_if.in_valid = 1'b1; s4_if.in_valid = 1'b1; s41_if.in_valid = 1'b1;
    tick;
    s1_if.in_valid = 1'b0; s4_if.in_valid = 1'b0; s41_if.in_valid = 1'b0;
    l1 = 0; l4 = 0; l41 = 0;
    p1 = '0; p4 = '0; p41 = '0;
    for (int c = 1; c <= 12; c++) begin
      tick;
      if (s1_if.out_valid && l1 == 0)   begin l1 = c;  p1 = s1_if.o;   end
      if (s4_if.out_valid && l4 == 0)   begin l4 = c;  p4 = s4_if.o;   end
      if (s41_if.out_valid && l41 == 0) begin l41 = c; p41 = s41_if.o; end
    end
    check("k1_lat", 64'(l1), 64'(8));
    check("k1_o", 64'(p1), 64'(e8));
    check("k4_lat", 64'(l4), 64'(2));
    check("k4_o", 64'(p4), 64'(e8));
    check("w4k1_lat", 64'(l41), 64'(4));
    check("w4k1_o", 64'(p41), 64'(e4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] a, b;
    mif.in_valid = 1'b0; mif.x = '0; mif.y = '0; mif.out_ready = 1'b0;
    s1_if.in_valid = 1'b0; s1_if.x = '0; s1_if.y = '0; s1_if.out_ready = 1'b1;
    s4_if.in_valid = 1'b0; s4_if.x = '0; s4_if.y = '0; s4_if.out_ready = 1'b1;
    s41_if.in_valid = 1'b0; s41_if.x = '0; s41_if.y = '0; s41_if.out_ready = 1'b1;
`ifdef MULT_SIGNED_EN
    mif.signed_mode = 1'b0; s1_if.signed_mode = 1'b0;
    s4_if.signed_mode = 1'b0; s41_if.signed_mode = 1'b0;
`endif

    // reset
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("rst_state", 64'(st), 64'(ST_IDLE));
    check("rst_in_ready", 64'(mif.in_ready), 64'(1));
    check("rst_out_valid", 64'(mif.out_valid), 64'(0));
    check("rst_o", 64'(mif.o), 64'(0));

    // latency: 255*255 and back-to-back accept spacing
    mif.x = 8'd255; mif.y = 8'd255; mif.in_valid = 1'b1; mif.out_ready = 1'b1;
    tick;
    mif.in_valid = 1'b0;
    check("lat_accept_state", 64'(st), 64'(ST_CALC));
    lat = 0;
    while (!mif.out_valid && lat < 20) begin
      check("lat_in_ready_low", 64'(mif.in_ready), 64'(0));
      tick;
      lat++;
    end
    check("lat_cycles", 64'(lat), 64'(4));
    check("lat_o", 64'(mif.o), 64'(16'hFE01));
    check("lat_done_in_ready", 64'(mif.in_ready), 64'(0));
    mif.x = 8'd3; mif.y = 8'd4; mif.in_valid = 1'b1;
    tick;
    check("ii_idle_state", 64'(st), 64'(ST_IDLE));
    check("ii_idle_in_ready", 64'(mif.in_ready), 64'(1));
    check("ii_idle_out_valid", 64'(mif.out_valid), 64'(0));
    tick;
    check("ii_second_accept", 64'(st), 64'(ST_CALC));
    mif.in_valid = 1'b0;
    wait_done(lat);
    check("ii_lat", 64'(lat), 64'(4));
    check("ii_o", 64'(mif.o), 64'(12));
    tick;

    // unsigned corners and random operands on the main instance
    run_main("u_zero", 8'd0, 8'd255, 1'b0, 16'd0);
    run_main("u_one", 8'd1, 8'd200, 1'b0, 16'd200);
    run_main("u_max_one", 8'd255, 8'd1, 1'b0, 16'h00FF);
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run_main("u_rand", a, b, 1'b0, {8'd0, a} * {8'd0, b});
    end

`ifdef MULT_SIGNED_EN
    run_main("s_min_min", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_main("s_m1_p1", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    run_main("s_max_min", 8'h7F, 8'h80, 1'b1, 16'hC080);
    run_main("s_off_ff_01", 8'hFF, 8'h01, 1'b0, 16'h00FF);
`endif

    // parameter sweep
    sweep(8'd0, 8'd0);
    sweep(8'd1, 8'd255);
    sweep(8'd255, 8'd255);
    sweep(8'd255, 8'd1);
    for (int i = 0; i < 4; i++) begin
      sweep(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // backpressure: 12*13 held in DONE
    mif.out_ready = 1'b0;
    mif.x = 8'd12; mif.y = 8'd13; mif.in_valid = 1'b1;
    tick;
    mif.in_valid = 1'b0;
    wait_done(lat);
    check("bp_lat", 64'(lat), 64'(4));
    for (int i = 0; i < 5; i++) begin
      mif.x = 8'($urandom_range(0, 255));
      mif.y = 8'($urandom_range(0, 255));
      mif.in_valid = 1'b1;
      tick;
      check("bp_out_valid", 64'(mif.out_valid), 64'(1));
      check("bp_o", 64'(mif.o), 64'(16'h009C));
      check("bp_in_ready", 64'(mif.in_ready), 64'(0));
    end
    mif.in_valid = 1'b0;
    mif.out_ready = 1'b1;
    tick;
    check("bp_release_state", 64'(st), 64'(ST_IDLE));
    check("bp_release_out_valid", 64'(mif.out_valid), 64'(0));
    tick;
    check("bp_single_handshake", 64'(mif.out_valid), 64'(0));

    // reset during CALC at cnt=2
    mif.x = 8'd200; mif.y = 8'd100; mif.in_valid = 1'b1;
    tick;
    mif.in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mrst_state", 64'(st), 64'(ST_IDLE));
    check("mrst_in_ready", 64'(mif.in_ready), 64'(1));
    check("mrst_out_valid", 64'(mif.out_valid), 64'(0));
    check("mrst_o", 64'(mif.o), 64'(0));
    run_main("mrst_next", 8'd3, 8'd5, 1'b0, 16'd15);

    // operands change every cycle during CALC
    mif.x = 8'd7; mif.y = 8'd9; mif.in_valid = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      mif.x = 8'($urandom_range(0, 255));
      mif.y = 8'($urandom_range(0, 255));
      tick;
    end
    check("hold_out_valid", 64'(mif.out_valid), 64'(1));
    check("hold_o", 64'(mif.o), 64'(63));
    mif.in_valid = 1'b0;
    tick;
    check("hold_idle", 64'(st), 64'(ST_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
